nes_bus: RTL and testbench

CPU-side bus responder for the NES core: the memory/peripheral end of the `cpu` address/data interface. It decodes `addr`/`write`/`d_out` from the CPU, returns read data on `d_in` with one-cycle latency, and owns the 2 KB work RAM, PRG-ROM port and PPU register window. It also implements the OAM DMA engine at $4014, stalling the CPU through `ready` while it copies a 256-byte page to PPU register $2004.

---
 rtl/nes_bus_pkg.sv | 50 +++++
 rtl/nes_ram.sv | 20 ++
 rtl/nes_bus.sv | 118 +++++++++++
 tb/tb_nes_bus.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus responder.
package nes_bus_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RAM_AW    = 11;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned PRG_AW    = 15;
  localparam int unsigned PPU_RW    = 3;

  localparam logic [ADDR_W-1:0] PPU_BASE   = 16'h2000;
  localparam logic [ADDR_W-1:0] UNMAP_BASE = 16'h4000;
  localparam logic [ADDR_W-1:0] DMA_REG    = 16'h4014;
  localparam logic [ADDR_W-1:0] ROM_BASE   = 16'h8000;
  localparam logic [PPU_RW-1:0] OAM_DATA   = 3'd4;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_DMA,
    REG_ROM,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  // One bus cycle as issued by whichever master owns the bus
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Map a 16-bit CPU address onto its region
  function automatic region_t decode(input logic [ADDR_W-1:0] addr);
    region_t r;
    if (addr < PPU_BASE)        r = REG_RAM;
    else if (addr < UNMAP_BASE) r = REG_PPU;
    else if (addr == DMA_REG)   r = REG_DMA;
    else if (addr >= ROM_BASE)  r = REG_ROM;
    else                        r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/nes_ram.sv
// 2 KB work RAM: single port, write at the edge, registered read.
module nes_ram
  import nes_bus_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Storage write and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nes_bus.sv
// CPU-side bus responder: address decode, read return, work RAM and OAM DMA.
module nes_bus
  import nes_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_d_out,
  output logic [DATA_W-1:0] cpu_d_in,
  output logic              cpu_ready,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [DATA_W-1:0] prg_data,
  output logic              ppu_cs,
  output logic [PPU_RW-1:0] ppu_reg,
  output logic              ppu_write,
  output logic [DATA_W-1:0] ppu_wdata,
  input  logic [DATA_W-1:0] ppu_rdata
);

  dma_state_t        state;
  logic [7:0]        page;
  logic [7:0]        idx;
  region_t           rd_region;
  logic [DATA_W-1:0] open_bus;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_data;
  bus_req_t          req;
  logic              active;
  region_t           region;
  logic              ram_we;

  // Return data for the access issued last cycle; open bus keeps the last value
  always_comb begin
    rd_data = open_bus;
    case (rd_region)
      REG_RAM: rd_data = ram_rdata;
      REG_PPU: rd_data = ppu_rdata;
      REG_ROM: rd_data = prg_data;
      default: rd_data = open_bus;
    endcase
  end

  // Pick the bus master for this cycle and decode its address
  always_comb begin
    req    = '{addr: cpu_addr, write: cpu_write, wdata: cpu_d_out};
    active = 1'b1;
    case (state)
      DMA_ALIGN: begin
        active    = 1'b0;
        req.write = 1'b0;
      end
      DMA_RD:  req = '{addr: {page, idx}, write: 1'b0, wdata: '0};
      DMA_WR:  req = '{addr: PPU_BASE | ADDR_W'(OAM_DATA), write: 1'b1, wdata: rd_data};
      default: ;
    endcase
    region = (active && !reset) ? decode(req.addr) : REG_NONE;
  end

  assign cpu_d_in  = rd_data;
  assign cpu_ready = (state == DMA_IDLE);
  assign ram_we    = (region == REG_RAM) && req.write;
  assign ppu_cs    = (region == REG_PPU);
  assign ppu_write = ppu_cs && req.write;
  assign ppu_reg   = ppu_cs ? req.addr[PPU_RW-1:0] : '0;
  assign ppu_wdata = ppu_write ? req.wdata : '0;
  assign prg_addr  = (region == REG_ROM) ? req.addr[PRG_AW-1:0] : '0;

  nes_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req.addr[RAM_AW-1:0]),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  // Remember which source answers next cycle, and the last value on the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_region <= REG_NONE;
      open_bus  <= '0;
    end else begin
      rd_region <= req.write ? REG_NONE : region;
      open_bus  <= rd_data;
    end
  end

  // OAM DMA sequencer: one align cycle, then 256 read/write pairs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DMA_IDLE;
      page  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        DMA_IDLE: begin
          if (region == REG_DMA && req.write) begin
            page  <= req.wdata;
            idx   <= '0;
            state <= DMA_ALIGN;
          end
        end
        DMA_ALIGN: state <= DMA_RD;
        DMA_RD:    state <= DMA_WR;
        DMA_WR: begin
          if (idx == 8'hFF) begin
            state <= DMA_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= DMA_RD;
          end
        end
        default:   state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_bus.sv
// Self-checking bench for nes_bus: vector table, random traffic against a
// memory-map model, and OAM DMA sequences.
module tb_nes_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic [7:0]  cpu_d_in;
  logic        cpu_ready;
  logic [14:0] prg_addr;
  logic [7:0]  prg_data;
  logic        ppu_cs;
  logic [2:0]  ppu_reg;
  logic        ppu_write;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rom [32768];
  logic [7:0]  ppu_regs [8];
  logic [7:0]  ram_m [2048];
  logic [7:0]  exp_bus;
  logic [11:0] ppu_log [$];
  logic [7:0]  nxt_prg;
  logic [7:0]  nxt_ppu;

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic        cs;
    logic        pw;
    logic [2:0]  rg;
    logic [7:0]  din;
  } vec_t;

  vec_t vt [12];

  nes_bus dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_write (cpu_write),
    .cpu_d_out (cpu_d_out),
    .cpu_d_in  (cpu_d_in),
    .cpu_ready (cpu_ready),
    .prg_addr  (prg_addr),
    .prg_data  (prg_data),
    .ppu_cs    (ppu_cs),
    .ppu_reg   (ppu_reg),
    .ppu_write (ppu_write),
    .ppu_wdata (ppu_wdata),
    .ppu_rdata (ppu_rdata)
  );

  always #5 clk = ~clk;

  // ROM/PPU responders and PPU access log, sampled mid-cycle
  always @(negedge clk) begin
    nxt_prg = rom[prg_addr];
    nxt_ppu = ppu_regs[ppu_reg];
    if (ppu_cs === 1'b1) ppu_log.push_back({ppu_write, ppu_reg, ppu_wdata});
  end

  // Responder data appears in the cycle after the address
  always @(posedge clk) begin
    #1;
    prg_data  = nxt_prg;
    ppu_rdata = nxt_ppu;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the edge, return mid-cycle once outputs settle
  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_addr  = a;
    cpu_write = w;
    cpu_d_out = d;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (a < 16'h2000) return ram_m[a[10:0]];
    if (a < 16'h4000) return ppu_regs[a[2:0]];
    if (a >= 16'h8000) return rom[a[14:0]];
    return exp_bus;
  endfunction

  // Cycle checked against the memory-map model
  task automatic model_cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
    logic in_ppu;
    in_ppu = (a >= 16'h2000) && (a < 16'h4000);
    cyc(a, w, d);
    chk("din", 16'(cpu_d_in), 16'(exp_bus));
    chk("ppu_cs", 16'(ppu_cs), 16'(in_ppu));
    if (in_ppu) begin
      chk("ppu_reg", 16'(ppu_reg), 16'(a[2:0]));
      chk("ppu_write", 16'(ppu_write), 16'(w));
      if (w) chk("ppu_wdata", 16'(ppu_wdata), 16'(d));
    end
    if (!w) exp_bus = ref_read(a);
    else if (a < 16'h2000) ram_m[a[10:0]] = d;
  endtask

  // Trigger a DMA and count the stalled cycles; optional extra trigger mid-run
  task automatic run_dma(input logic [7:0] pg, input int inj_at, input logic [7:0] inj_pg,
                         output int low);
    ppu_log.delete();
    cyc(16'h4014, 1'b1, pg);
    low = 0;
    for (int n = 1; n <= 600; n++) begin
      if (n == inj_at) cyc(16'h4014, 1'b1, inj_pg);
      else cyc(16'h0400, 1'b0, 8'h00);
      if (cpu_ready === 1'b1) break;
      low++;
    end
  endtask

  task automatic chk_dma(input string name, input int low, input logic [7:0] exp_fixed,
                         input logic use_fixed, input logic [7:0] pg);
    int cnt;
    logic [7:0] e;
    chk({name, "_ready_low"}, 16'(low), 16'd513);
    chk({name, "_count"}, 16'(ppu_log.size()), 16'd256);
    cnt = (ppu_log.size() < 256) ? ppu_log.size() : 256;
    for (int i = 0; i < cnt; i++) begin
      e = use_fixed ? exp_fixed : ref_read({pg, 8'(i)});
      chk({name, "_xfer"}, 16'(ppu_log[i]), 16'({1'b1, 3'd4, e}));
    end
  endtask

  initial begin
    int          low;
    int          n;
    int          r;
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic [7:0]  e;

    for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom);
    rom[32764] = 8'h34;
    for (int i = 0; i < 8; i++) ppu_regs[i] = 8'($urandom);
    ppu_regs[2] = 8'h80;

    reset     = 1'b1;
    cpu_addr  = 16'h2005;
    cpu_write = 1'b1;
    cpu_d_out = 8'h77;

    // Reset state, with a PPU write and a ROM read held on the inputs
    cyc(16'h2005, 1'b1, 8'h77);
    chk("rst_ready", 16'(cpu_ready), 16'd1);
    chk("rst_din", 16'(cpu_d_in), 16'd0);
    chk("rst_cs", 16'(ppu_cs), 16'd0);
    chk("rst_pw", 16'(ppu_write), 16'd0);
    chk("rst_reg", 16'(ppu_reg), 16'd0);
    chk("rst_wdata", 16'(ppu_wdata), 16'd0);
    cyc(16'hFFFF, 1'b0, 8'h00);
    chk("rst_prg", 16'(prg_addr), 16'd0);
    cyc(16'h5000, 1'b1, 8'h00);
    reset = 1'b0;

    // Directed vectors: din is the value returned for the previous row
    vt[0]  = '{16'h0005, 1'b1, 8'hAA, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[1]  = '{16'h0805, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[2]  = '{16'h1805, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hAA};
    vt[3]  = '{16'h3FFE, 1'b1, 8'h3F, 1'b1, 1'b1, 3'd6, 8'hAA};
    vt[4]  = '{16'h2002, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'hAA};
    vt[5]  = '{16'hFFFC, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80};
    vt[6]  = '{16'h5000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h34};
    vt[7]  = '{16'h8005, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0, 8'h34};
    vt[8]  = '{16'h0005, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h34};
    vt[9]  = '{16'h4014, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hAA};
    vt[10] = '{16'h2007, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 8'hAA};
    vt[11] = '{16'h0805, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, ppu_regs[7]};
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].a, vt[i].w, vt[i].d);
      chk("vec_din", 16'(cpu_d_in), 16'(vt[i].din));
      chk("vec_cs", 16'(ppu_cs), 16'(vt[i].cs));
      chk("vec_ready", 16'(cpu_ready), 16'd1);
      if (vt[i].cs) begin
        chk("vec_reg", 16'(ppu_reg), 16'(vt[i].rg));
        chk("vec_pw", 16'(ppu_write), 16'(vt[i].pw));
        if (vt[i].pw) chk("vec_wdata", 16'(ppu_wdata), 16'(vt[i].d));
      end
    end
    exp_bus = 8'hAA;

    // Fill all of RAM through the bus, then the DMA source pages via mirrors
    for (int i = 0; i < 2048; i++) model_cyc(16'(i), 1'b1, 8'($urandom));
    for (int i = 0; i < 256; i++) model_cyc(16'h0A00 + 16'(i), 1'b1, 8'(i) ^ 8'h5A);
    for (int i = 0; i < 256; i++) model_cyc(16'h1300 + 16'(i), 1'b1, 8'(i) ^ 8'hC3);

    // Random traffic over every region
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h7FFF));
        default: a = 16'($urandom_range(16'h8000, 16'hFFFF));
      endcase
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (a == 16'h4014) w = 1'b0;
      model_cyc(a, w, d);
    end

    // Plain DMA from RAM page $02
    run_dma(8'h02, 0, 8'h00, low);
    chk_dma("dma", low, 8'h00, 1'b0, 8'h02);

    // Trigger during a running transfer must be ignored
    run_dma(8'h02, 50, 8'h03, low);
    chk_dma("dma_ign", low, 8'h00, 1'b0, 8'h02);

    // Unmapped page: every byte is the open-bus value left by the read before
    cyc(16'h0005, 1'b0, 8'h00);
    e = ram_m[5];
    run_dma(8'h50, 0, 8'h00, low);
    chk_dma("dma_open", low, e, 1'b1, 8'h50);

    // Reset in the middle of a transfer, then a clean restart
    ppu_log.delete();
    cyc(16'h4014, 1'b1, 8'h02);
    n = 0;
    while (ppu_log.size() < 100 && n < 400) begin
      cyc(16'h0400, 1'b0, 8'h00);
      n++;
    end
    chk("mid_reach", 16'(ppu_log.size()), 16'd100);
    reset = 1'b1;
    #1;
    chk("mid_ready", 16'(cpu_ready), 16'd1);
    chk("mid_cs", 16'(ppu_cs), 16'd0);
    chk("mid_din", 16'(cpu_d_in), 16'd0);
    cyc(16'h0400, 1'b0, 8'h00);
    cyc(16'h0400, 1'b0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(16'h0400, 1'b0, 8'h00);
      chk("post_rst_ready", 16'(cpu_ready), 16'd1);
    end
    chk("post_rst_ppu", 16'(ppu_log.size()), 16'd100);
    run_dma(8'h02, 0, 8'h00, low);
    chk_dma("dma_restart", low, 8'h00, 1'b0, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
